// File: rtl/cache_lowmem_bridge_pkg.sv
// rtl/cache_lowmem_bridge_pkg.sv - shared types and helpers for the cache lowmem bridge
//
// Purpose: state encoding, default burst address step and the burst word-count
// rule shared by the bridge and anything that needs to reason about its bursts.
// Ports: none (package).

package cache_lowmem_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_REQ = 3'd1,
      ST_WR_REQ = 3'd2,
      ST_WR_GAP = 3'd3,
      ST_DRAIN  = 3'd4
   } bridge_state_e;

   localparam int unsigned ADDR_STEP_DEF = 4;
   localparam int unsigned CNT_W         = 9;

   // Number of words in a transfer. A 9-bit result is needed because an
   // 8-bit length of zero may stand for a full 256-word line.
   function automatic logic [CNT_W-1:0] burst_words(
      input logic       burst_en,
      input logic [7:0] burst_length,
      input logic       len0_is_max
   );
      logic [CNT_W-1:0] n;
      if (!burst_en) begin
         n = 9'd1;
      end else if (burst_length == 8'd0) begin
         n = len0_is_max ? 9'd256 : 9'd1;
      end else begin
         n = {1'b0, burst_length};
      end
      return n;
   endfunction

endpackage

// File: rtl/cache_lowmem_bridge.sv
// rtl/cache_lowmem_bridge.sv - cache lowmem burst port to single-word memory bus bridge
//
// Purpose: turns cache line fills (read bursts), line writebacks (write bursts)
// and single uncached accesses into one req/ack memory transaction per word,
// returning a one-cycle lowmem_ready strobe per word so the cache can stream.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   burst_en        1: burst of burst_length words, 0: single word
//   burst_length    words in burst (0 = 256 when LEN0_IS_MAX), sampled at start
//   lowmem_a        byte base address, sampled at start
//   lowmem_d        write data of the current word
//   lowmem_we/rd    write/read request levels, held until the last ready
//   lowmem_spo      read data, valid while lowmem_ready is high
//   lowmem_ready    per-word strobe (read data valid / write word taken)
//   burst_last      marks the final lowmem_ready of a transfer
//   mem_a/mem_d     memory word address / write data
//   mem_we/mem_rd   memory request levels, held until mem_ack
//   mem_spo         memory read data, valid with mem_ack
//   mem_ack         one-cycle completion pulse from memory

module cache_lowmem_bridge
   import cache_lowmem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_STEP   = ADDR_STEP_DEF,
   parameter bit          LEN0_IS_MAX = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        burst_en,
   input  logic [7:0]  burst_length,
   input  logic [31:0] lowmem_a,
   input  logic [31:0] lowmem_d,
   input  logic        lowmem_we,
   input  logic        lowmem_rd,
   output logic [31:0] lowmem_spo,
   output logic        lowmem_ready,
   output logic        burst_last,
   output logic [31:0] mem_a,
   output logic [31:0] mem_d,
   output logic        mem_we,
   output logic        mem_rd,
   input  logic [31:0] mem_spo,
   input  logic        mem_ack
);

   bridge_state_e    state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [31:0]      mem_a_q, mem_a_d;
   logic [31:0]      mem_d_q, mem_d_d;
   logic             mem_we_q, mem_we_d;
   logic             mem_rd_q, mem_rd_d;
   logic [31:0]      lowmem_spo_q, lowmem_spo_d;
   logic             lowmem_ready_q, lowmem_ready_d;
   logic             burst_last_q, burst_last_d;

   logic             last_word;
   logic [31:0]      next_a;

   assign last_word = (remaining_q == 9'd1);
   // Plain 32-bit add: addresses wrap modulo 2^32 with no line alignment.
   assign next_a    = mem_a_q + 32'(ADDR_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         remaining_q    <= '0;
         mem_a_q        <= '0;
         mem_d_q        <= '0;
         mem_we_q       <= 1'b0;
         mem_rd_q       <= 1'b0;
         lowmem_spo_q   <= '0;
         lowmem_ready_q <= 1'b0;
         burst_last_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         remaining_q    <= remaining_d;
         mem_a_q        <= mem_a_d;
         mem_d_q        <= mem_d_d;
         mem_we_q       <= mem_we_d;
         mem_rd_q       <= mem_rd_d;
         lowmem_spo_q   <= lowmem_spo_d;
         lowmem_ready_q <= lowmem_ready_d;
         burst_last_q   <= burst_last_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      mem_a_d        = mem_a_q;
      mem_d_d        = mem_d_q;
      mem_we_d       = mem_we_q;
      mem_rd_d       = mem_rd_q;
      lowmem_spo_d   = lowmem_spo_q;
      lowmem_ready_d = 1'b0;
      burst_last_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Write wins when the cache raises both levels together.
            if (lowmem_we || lowmem_rd) begin
               mem_a_d     = lowmem_a;
               remaining_d = burst_words(burst_en, burst_length, LEN0_IS_MAX);
               if (lowmem_we) begin
                  mem_we_d = 1'b1;
                  mem_d_d  = lowmem_d;
                  state_d  = ST_WR_REQ;
               end else begin
                  mem_rd_d = 1'b1;
                  state_d  = ST_RD_REQ;
               end
            end
         end

         ST_RD_REQ: begin
            if (!lowmem_rd) begin
               // Cache gave up: the word in flight is completed but not returned.
               if (mem_ack) begin
                  mem_rd_d    = 1'b0;
                  remaining_d = '0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (mem_ack) begin
               lowmem_spo_d   = mem_spo;
               lowmem_ready_d = 1'b1;
               remaining_d    = remaining_q - 9'd1;
               if (last_word) begin
                  burst_last_d = 1'b1;
                  mem_rd_d     = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  // mem_rd stays high so the next word issues without a gap.
                  mem_a_d = next_a;
               end
            end
         end

         ST_WR_REQ: begin
            if (!lowmem_we) begin
               if (mem_ack) begin
                  mem_we_d    = 1'b0;
                  remaining_d = '0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (mem_ack) begin
               lowmem_ready_d = 1'b1;
               mem_we_d       = 1'b0;
               remaining_d    = remaining_q - 9'd1;
               if (last_word) begin
                  burst_last_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_WR_GAP;
               end
            end
         end

         ST_WR_GAP: begin
            // The ready strobe is visible this cycle, so lowmem_d already
            // carries the next word when it is captured here.
            if (!lowmem_we) begin
               remaining_d = '0;
               state_d     = ST_IDLE;
            end else begin
               mem_d_d  = lowmem_d;
               mem_a_d  = next_a;
               mem_we_d = 1'b1;
               state_d  = ST_WR_REQ;
            end
         end

         ST_DRAIN: begin
            if (mem_ack) begin
               mem_rd_d    = 1'b0;
               mem_we_d    = 1'b0;
               remaining_d = '0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            mem_rd_d    = 1'b0;
            mem_we_d    = 1'b0;
            remaining_d = '0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   assign lowmem_spo   = lowmem_spo_q;
   assign lowmem_ready = lowmem_ready_q;
   assign burst_last   = burst_last_q;
   assign mem_a        = mem_a_q;
   assign mem_d        = mem_d_q;
   assign mem_we       = mem_we_q;
   assign mem_rd       = mem_rd_q;

endmodule

// File: tb/tb_cache_lowmem_bridge.sv
// tb/tb_cache_lowmem_bridge.sv - scoreboard bench for cache_lowmem_bridge

module tb_cache_lowmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        burst_en;
   logic [7:0]  burst_length;
   logic [31:0] lowmem_a;
   logic [31:0] lowmem_d;
   logic        lowmem_we;
   logic        lowmem_rd;
   logic [31:0] lowmem_spo;
   logic        lowmem_ready;
   logic        burst_last;
   logic [31:0] mem_a;
   logic [31:0] mem_d;
   logic        mem_we;
   logic        mem_rd;
   logic [31:0] mem_spo;
   logic        mem_ack;

   always #5 clk = ~clk;

   cache_lowmem_bridge dut (
      .clk          (clk),
      .rst          (rst),
      .burst_en     (burst_en),
      .burst_length (burst_length),
      .lowmem_a     (lowmem_a),
      .lowmem_d     (lowmem_d),
      .lowmem_we    (lowmem_we),
      .lowmem_rd    (lowmem_rd),
      .lowmem_spo   (lowmem_spo),
      .lowmem_ready (lowmem_ready),
      .burst_last   (burst_last),
      .mem_a        (mem_a),
      .mem_d        (mem_d),
      .mem_we       (mem_we),
      .mem_rd       (mem_rd),
      .mem_spo      (mem_spo),
      .mem_ack      (mem_ack)
   );

   typedef struct {
      logic [31:0] spo;
      logic        last;
      logic        rd;
   } rdy_t;

   typedef struct {
      logic [31:0] a;
      logic        we;
   } req_t;

   int   checks = 0;
   int   errors = 0;
   rdy_t rdy_q[$];
   req_t req_q[$];

   logic [31:0] mem [logic [31:0]];
   int          lat = 1;
   bit          pend = 0;
   int          cnt = 0;
   logic [31:0] p_a, p_d;
   logic        p_we;
   int          acks = 0;
   bit          hold_chk = 1;

   logic [31:0] wdata [0:3];
   int          widx = 0;
   bit          cache_wr = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0] ^ 16'hBEEF, ~a[31:16]};
   endfunction

   // One clock: scoreboard monitor, memory model, then cache model reaction.
   task automatic step();
      rdy_t e;
      req_t r;
      @(negedge clk);
      if (lowmem_ready === 1'b1) begin
         if (rdy_q.size() == 0) begin
            expect_eq("unexp_ready", 1, 0);
         end else begin
            e = rdy_q.pop_front();
            expect_eq("burst_last", {31'd0, burst_last}, {31'd0, e.last});
            if (e.rd) expect_eq("lowmem_spo", lowmem_spo, e.spo);
         end
         if (cache_wr) begin
            widx++;
            if (widx < 4) lowmem_d = wdata[widx];
         end
         if (burst_last === 1'b1) begin
            lowmem_rd = 1'b0;
            lowmem_we = 1'b0;
         end
      end else if (burst_last === 1'b1) begin
         expect_eq("last_no_ready", 1, 0);
      end

      mem_ack = 1'b0;
      mem_spo = 32'hDEAD_DEAD;
      if (pend) begin
         if (cnt == 0) begin
            if (hold_chk) begin
               expect_eq("hold_a", mem_a, p_a);
               expect_eq("hold_req", {31'd0, p_we ? mem_we : mem_rd}, 1);
               if (p_we) expect_eq("hold_d", mem_d, p_d);
            end
            if (p_we) mem[p_a] = p_d;
            else      mem_spo = rd_model(p_a);
            mem_ack = 1'b1;
            pend    = 0;
            acks++;
         end else begin
            cnt--;
         end
      end else if (mem_rd === 1'b1 || mem_we === 1'b1) begin
         if (req_q.size() == 0) begin
            expect_eq("unexp_req", 1, 0);
         end else begin
            r = req_q.pop_front();
            expect_eq("mem_a", mem_a, r.a);
            expect_eq("mem_we", {31'd0, mem_we}, {31'd0, r.we});
         end
         p_a  = mem_a;
         p_d  = mem_d;
         p_we = mem_we;
         pend = 1;
         cnt  = lat - 1;
      end
   endtask

   task automatic push_xfer(input logic we, input logic en, input logic [7:0] len,
                            input logic [31:0] base);
      int          n;
      logic [31:0] a;
      rdy_t        e;
      req_t        r;
      n = !en ? 1 : ((len == 8'd0) ? 256 : int'(len));
      for (int i = 0; i < n; i++) begin
         a      = base + 32'(i * 4);
         r.a    = a;
         r.we   = we;
         req_q.push_back(r);
         e.spo  = rd_model(a);
         e.last = (i == n - 1);
         e.rd   = !we;
         rdy_q.push_back(e);
      end
   endtask

   task automatic start(input logic we, input logic rd, input logic en,
                        input logic [7:0] len, input logic [31:0] base);
      cache_wr     = we;
      widx         = 0;
      lowmem_d     = we ? wdata[0] : 32'h0;
      burst_en     = en;
      burst_length = len;
      lowmem_a     = base;
      lowmem_we    = we;
      lowmem_rd    = rd;
   endtask

   task automatic run_xfer(input logic we, input logic rd, input logic en,
                           input logic [7:0] len, input logic [31:0] base,
                           input int budget, output int steps);
      push_xfer(we, en, len, base);
      start(we, rd, en, len, base);
      steps = 0;
      while (rdy_q.size() != 0 && steps < budget) begin
         step();
         steps++;
      end
      expect_eq("xfer_timeout", rdy_q.size(), 0);
      repeat (4) step();
      expect_eq("idle_rd", {31'd0, mem_rd}, 0);
      expect_eq("idle_we", {31'd0, mem_we}, 0);
      expect_eq("req_left", req_q.size(), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int          st;
      int          a0;
      logic [31:0] a;

      rst = 1'b1; burst_en = 0; burst_length = 0; lowmem_a = 0; lowmem_d = 0;
      lowmem_we = 0; lowmem_rd = 0; mem_spo = 0; mem_ack = 0;
      step();
      step();
      expect_eq("rst_spo",   lowmem_spo, 0);
      expect_eq("rst_ready", {31'd0, lowmem_ready}, 0);
      expect_eq("rst_last",  {31'd0, burst_last}, 0);
      expect_eq("rst_mem_a", mem_a, 0);
      expect_eq("rst_mem_d", mem_d, 0);
      expect_eq("rst_we",    {31'd0, mem_we}, 0);
      expect_eq("rst_rd",    {31'd0, mem_rd}, 0);
      rst = 1'b0;
      step();

      // 32-word line fill, fastest memory: 2-cycle word period
      lat = 1;
      run_xfer(1'b0, 1'b1, 1'b1, 8'd32, 32'h0000_1000, 200, st);
      expect_eq("rd_period", st, 65);

      // 4-word writeback with slow memory
      lat = 3;
      for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
      run_xfer(1'b1, 1'b0, 1'b1, 8'd4, 32'h0000_2000, 100, st);
      for (int i = 0; i < 4; i++) begin
         a = 32'h0000_2000 + 32'(i * 4);
         expect_eq("wr_mem", mem.exists(a) ? mem[a] : 32'h0, 32'hA0 + 32'(i));
      end

      // single uncached read, burst_length ignored
      lat = 2;
      run_xfer(1'b0, 1'b1, 1'b0, 8'h55, 32'h0000_3004, 50, st);

      // length 0 = 256 words, address wraps through zero
      lat = 1;
      run_xfer(1'b0, 1'b1, 1'b1, 8'd0, 32'hFFFF_FF80, 700, st);
      expect_eq("len0_period", st, 513);

      // reset while word 5 is pending at the memory
      lat = 3;
      push_xfer(1'b0, 1'b1, 8'd16, 32'h0000_6000);
      start(1'b0, 1'b1, 1'b1, 8'd16, 32'h0000_6000);
      st = 0;
      while (rdy_q.size() > 12 && st < 100) begin
         step();
         st++;
      end
      expect_eq("rst_pend", {31'd0, pend}, 1);
      rst       = 1'b1;
      lowmem_rd = 1'b0;
      hold_chk  = 0;
      rdy_q.delete();
      req_q.delete();
      a0 = acks;
      step();
      expect_eq("rst_mid_rd",    {31'd0, mem_rd}, 0);
      expect_eq("rst_mid_ready", {31'd0, lowmem_ready}, 0);
      expect_eq("rst_mid_a",     mem_a, 0);
      rst = 1'b0;
      repeat (10) step();
      expect_eq("late_ack", acks - a0, 1);
      hold_chk = 1;
      run_xfer(1'b0, 1'b1, 1'b1, 8'd2, 32'h0000_6100, 50, st);

      // we and rd together: the write wins
      lat = 1;
      wdata[0] = 32'hB0; wdata[1] = 32'hB1; wdata[2] = 32'hB2; wdata[3] = 32'hB3;
      run_xfer(1'b1, 1'b1, 1'b1, 8'd2, 32'h0000_7000, 50, st);
      expect_eq("both_mem0", mem.exists(32'h7000) ? mem[32'h7000] : 32'h0, 32'hB0);
      expect_eq("both_mem1", mem.exists(32'h7004) ? mem[32'h7004] : 32'h0, 32'hB1);

      // cache drops rd mid-burst while a word is in flight
      lat = 3;
      push_xfer(1'b0, 1'b1, 8'd8, 32'h0000_5000);
      start(1'b0, 1'b1, 1'b1, 8'd8, 32'h0000_5000);
      st = 0;
      while (rdy_q.size() > 6 && st < 100) begin
         step();
         st++;
      end
      expect_eq("abort_pend", {31'd0, pend}, 1);
      lowmem_rd = 1'b0;
      rdy_q.delete();
      req_q.delete();
      a0 = acks;
      repeat (15) step();
      expect_eq("abort_acks", acks - a0, 1);
      expect_eq("abort_rd", {31'd0, mem_rd}, 0);
      run_xfer(1'b0, 1'b1, 1'b1, 8'd3, 32'h0000_5100, 50, st);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
